// File: rtl/ntt_stage_ctrl.sv
// Stage/group/position sequencer for a shared NTT/INTT butterfly datapath.
// Issues one butterfly per cycle and produces read/write strobes and addresses aligned to the pipeline latencies.
module ntt_stage_ctrl #(
    parameter int N      = 256,
    parameter int LOGN   = 8,
    parameter int AW     = 8,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr_u,
    output logic [AW-1:0] rd_addr_t,
    output logic [AW-1:0] tw_addr,
    output logic          bf_sel,
    output logic          bf_vld,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr_u,
    output logic [AW-1:0] wr_addr_t,
    output logic          busy,
    output logic          done
);

    localparam int D  = RD_LAT + BF_LAT;
    localparam int SW = (D > 1) ? $clog2(D) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] STALL = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [AW-1:0] HALF      = AW'(N / 2);
    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [AW-1:0] LAST_S    = AW'(LOGN - 1);
    localparam logic [SW-1:0] STALL_END = SW'(D - 1);
    localparam logic [SW-1:0] S_ONE     = SW'(1);

    logic [1:0]    state;
    logic          mode_q;
    logic [AW-1:0] s, g, p, base, cnt;
    logic [SW-1:0] stall_cnt;

    logic [AW-1:0] half_s, len, u_addr, t_addr, tw;

    // NOTE: every variable is assigned on every path through this block, so no latch can be inferred.
    always_comb begin
        half_s = HALF >> s;
        len    = mode_q ? half_s : (ONE << s);
        u_addr = base + p;
        t_addr = u_addr + len;
        // INTT twiddle is (N>>s)-1-g; at s=0 N wraps to 0 in AW bits, and the modular subtract still lands on N-1-g.
        tw     = mode_q ? ((ONE << s) + g) : ((half_s << 1) - ONE - g);
    end

    assign rd_en     = (state == ISSUE);
    assign rd_addr_u = rd_en ? u_addr : '0;
    assign rd_addr_t = rd_en ? t_addr : '0;
    assign tw_addr   = rd_en ? tw : '0;
    assign busy      = (state == ISSUE) || (state == STALL);
    assign done      = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            s         <= '0;
            g         <= '0;
            p         <= '0;
            base      <= '0;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        s      <= '0;
                        g      <= '0;
                        p      <= '0;
                        base   <= '0;
                        cnt    <= '0;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt <= cnt + ONE;
                    if (p == len - ONE) begin
                        p    <= '0;
                        g    <= g + ONE;
                        base <= base + (len << 1);
                    end else begin
                        p <= p + ONE;
                    end
                    if (cnt == HALF - ONE) begin
                        stall_cnt <= '0;
                        state     <= STALL;
                    end
                end
                STALL: begin
                    if (stall_cnt == STALL_END) begin
                        if (s == LAST_S) begin
                            state <= DONE;
                        end else begin
                            s     <= s + ONE;
                            g     <= '0;
                            p     <= '0;
                            base  <= '0;
                            cnt   <= '0;
                            state <= ISSUE;
                        end
                    end else begin
                        stall_cnt <= stall_cnt + S_ONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [D-1:0]      vld_sr;
    logic [RD_LAT-1:0] sel_sr;
    logic [AW-1:0]     wu_sr [D];
    logic [AW-1:0]     wt_sr [D];

    // NOTE: the delay lines are reset explicitly so no write strobe from an aborted transform survives reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr <= '0;
            sel_sr <= '0;
            for (int i = 0; i < D; i++) begin
                wu_sr[i] <= '0;
                wt_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= rd_en;
            sel_sr[0] <= rd_en & mode_q;
            wu_sr[0]  <= rd_addr_u;
            wt_sr[0]  <= rd_addr_t;
            for (int i = 1; i < D; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                wu_sr[i]  <= wu_sr[i-1];
                wt_sr[i]  <= wt_sr[i-1];
            end
            for (int i = 1; i < RD_LAT; i++) begin
                sel_sr[i] <= sel_sr[i-1];
            end
        end
    end

    assign bf_vld    = vld_sr[RD_LAT-1];
    assign bf_sel    = sel_sr[RD_LAT-1];
    assign wr_en     = vld_sr[D-1];
    assign wr_addr_u = wu_sr[D-1];
    assign wr_addr_t = wt_sr[D-1];

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Bench for ntt_stage_ctrl: an N=8 instance and a default N=256 instance, each compared every cycle
// against a closed-form reference derived from stage/group/position arithmetic.
module tb_ntt_stage_ctrl;

    localparam int RD_LAT = 1;
    localparam int BF_LAT = 14;
    localparam int DLY    = RD_LAT + BF_LAT;

    typedef struct packed {
        logic       rd;
        logic [7:0] u, t, tw;
        logic       vld, sel, wr;
        logic [7:0] wu, wt;
        logic       busy, done;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic start_s, mode_s, start_l, mode_l;

    logic       rd_en_s, bf_sel_s, bf_vld_s, wr_en_s, busy_s, done_s;
    logic [2:0] rd_u_s, rd_t_s, tw_s, wr_u_s, wr_t_s;
    logic       rd_en_l, bf_sel_l, bf_vld_l, wr_en_l, busy_l, done_l;
    logic [7:0] rd_u_l, rd_t_l, tw_l, wr_u_l, wr_t_l;

    obs_t obs_s, obs_l;

    int total = 0;
    int bad   = 0;
    int rd_cnt, wr_cnt, done_cyc;
    logic [23:0] rec_i[$];
    int rec_c[$];
    int rec_w[$];

    int ntt_tab [12][3] = '{'{0,4,1}, '{1,5,1}, '{2,6,1}, '{3,7,1},
                            '{0,2,2}, '{1,3,2}, '{4,6,3}, '{5,7,3},
                            '{0,1,4}, '{2,3,5}, '{4,5,6}, '{6,7,7}};
    int intt_tab[12][3] = '{'{0,1,7}, '{2,3,6}, '{4,5,5}, '{6,7,4},
                            '{0,2,3}, '{1,3,3}, '{4,6,2}, '{5,7,2},
                            '{0,4,1}, '{1,5,1}, '{2,6,1}, '{3,7,1}};
    int iss_cyc [12] = '{1, 2, 3, 4, 20, 21, 22, 23, 39, 40, 41, 42};
    int wr_cyc  [12] = '{16, 17, 18, 19, 35, 36, 37, 38, 54, 55, 56, 57};

    always #5 clk = ~clk;

    ntt_stage_ctrl #(.N(8), .LOGN(3), .AW(3), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .mode(mode_s),
        .rd_en(rd_en_s), .rd_addr_u(rd_u_s), .rd_addr_t(rd_t_s), .tw_addr(tw_s),
        .bf_sel(bf_sel_s), .bf_vld(bf_vld_s), .wr_en(wr_en_s),
        .wr_addr_u(wr_u_s), .wr_addr_t(wr_t_s), .busy(busy_s), .done(done_s)
    );

    ntt_stage_ctrl #(.N(256), .LOGN(8), .AW(8), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut_l (
        .clk(clk), .rst(rst), .start(start_l), .mode(mode_l),
        .rd_en(rd_en_l), .rd_addr_u(rd_u_l), .rd_addr_t(rd_t_l), .tw_addr(tw_l),
        .bf_sel(bf_sel_l), .bf_vld(bf_vld_l), .wr_en(wr_en_l),
        .wr_addr_u(wr_u_l), .wr_addr_t(wr_t_l), .busy(busy_l), .done(done_l)
    );

    always_comb begin
        obs_s = '{rd: rd_en_s, u: {5'b0, rd_u_s}, t: {5'b0, rd_t_s}, tw: {5'b0, tw_s},
                  vld: bf_vld_s, sel: bf_sel_s, wr: wr_en_s,
                  wu: {5'b0, wr_u_s}, wt: {5'b0, wr_t_s}, busy: busy_s, done: done_s};
        obs_l = '{rd: rd_en_l, u: rd_u_l, t: rd_t_l, tw: tw_l,
                  vld: bf_vld_l, sel: bf_sel_l, wr: wr_en_l,
                  wu: wr_u_l, wt: wr_t_l, busy: busy_l, done: done_l};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Which butterfly (if any) is issued x cycles after start acceptance.
    function automatic bit issue_at(input int n, input int logn, input bit md, input int x,
                                    output int u, output int t, output int tw);
        int per, k, s, j, len, g, p;
        u = 0; t = 0; tw = 0;
        per = n / 2 + DLY;
        if (x < 1 || x > logn * per) return 1'b0;
        k = x - 1;
        s = k / per;
        j = k % per;
        if (j >= n / 2) return 1'b0;
        len = md ? (n >> (s + 1)) : (1 << s);
        g  = j / len;
        p  = j % len;
        u  = g * 2 * len + p;
        t  = u + len;
        tw = md ? ((1 << s) + g) : ((n >> s) - 1 - g);
        return 1'b1;
    endfunction

    function automatic obs_t model(input int n, input int logn, input bit md, input int c);
        obs_t e;
        int u, t, tw, per;
        e   = '0;
        per = n / 2 + DLY;
        if (issue_at(n, logn, md, c, u, t, tw)) begin
            e.rd = 1'b1; e.u = 8'(u); e.t = 8'(t); e.tw = 8'(tw);
        end
        if (issue_at(n, logn, md, c - RD_LAT, u, t, tw)) begin
            e.vld = 1'b1; e.sel = md;
        end
        if (issue_at(n, logn, md, c - DLY, u, t, tw)) begin
            e.wr = 1'b1; e.wu = 8'(u); e.wt = 8'(t);
        end
        e.busy = (c >= 1) && (c <= logn * per);
        e.done = (c == 1 + logn * per);
        return e;
    endfunction

    task automatic drive(input bit big, input logic st, input logic md);
        if (big) begin
            start_l = st; mode_l = md;
        end else begin
            start_s = st; mode_s = md;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One whole transform from start acceptance (cycle 0) to done, checked every cycle.
    task automatic run_xform(input bit big, input bit md, input bit noise, input int abort_at);
        int n, logn, last;
        obs_t o, e;
        n    = big ? 256 : 8;
        logn = big ? 8 : 3;
        last = 1 + logn * (n / 2 + DLY);
        rec_i.delete(); rec_c.delete(); rec_w.delete();
        rd_cnt = 0; wr_cnt = 0; done_cyc = -1;
        for (int c = 0; c <= last; c++) begin
            if (c == 0)
                drive(big, 1'b1, md);
            else if (noise)
                drive(big, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                drive(big, 1'b0, md);
            if (c == abort_at) rst = 1'b0;
            #1;
            o = big ? obs_l : obs_s;
            if (c == abort_at) begin
                check($sformatf("reset_same_cycle c=%0d", c), {18'b0, o}, 64'b0);
                drive(big, 1'b0, 1'b0);
                return;
            end
            e = model(n, logn, md, c);
            check($sformatf("%s md=%0d c=%0d", big ? "n256" : "n8", md, c), {18'b0, o}, {18'b0, e});
            if (o.rd) begin
                rd_cnt++;
                rec_i.push_back({o.u, o.t, o.tw});
                rec_c.push_back(c);
            end
            if (o.wr) begin
                wr_cnt++;
                rec_w.push_back(c);
            end
            if (o.done) done_cyc = c;
            step();
        end
        drive(big, 1'b0, 1'b0);
    endtask

    // Compare a recorded N=8 transform against the literal issue/write-back tables.
    task automatic check_tables(input bit md, input string tag);
        int eu, et, etw;
        check({tag, " issue_count"}, 64'(rec_i.size()), 64'd12);
        check({tag, " wr_count"}, 64'(rec_w.size()), 64'd12);
        check({tag, " done_cycle"}, 64'(done_cyc), 64'd58);
        for (int i = 0; i < 12; i++) begin
            eu  = md ? ntt_tab[i][0] : intt_tab[i][0];
            et  = md ? ntt_tab[i][1] : intt_tab[i][1];
            etw = md ? ntt_tab[i][2] : intt_tab[i][2];
            if (i < rec_i.size())
                check($sformatf("%s issue%0d", tag, i), {8'b0, rec_c[i], rec_i[i]},
                      {8'b0, iss_cyc[i], 8'(eu), 8'(et), 8'(etw)});
            if (i < rec_w.size())
                check($sformatf("%s wr%0d", tag, i), 64'(rec_w[i]), 64'(wr_cyc[i]));
        end
    endtask

    initial begin
        rst = 1'b0;
        start_s = 1'b0; mode_s = 1'b0; start_l = 1'b0; mode_l = 1'b0;
        repeat (3) step();
        check("reset_small", {18'b0, obs_s}, 64'b0);
        check("reset_big", {18'b0, obs_l}, 64'b0);
        rst = 1'b1;
        step();
        check("idle_small", {18'b0, obs_s}, 64'b0);

        run_xform(1'b0, 1'b1, 1'b0, -1);
        check_tables(1'b1, "ntt8");
        run_xform(1'b0, 1'b1, 1'b0, -1);
        check_tables(1'b1, "ntt8_b2b");
        run_xform(1'b0, 1'b0, 1'b0, -1);
        check_tables(1'b0, "intt8");

        run_xform(1'b0, 1'b1, 1'b0, 30);
        repeat (2) begin
            step();
            check("reset_hold", {18'b0, obs_s}, 64'b0);
        end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("post_reset_idle%0d", i), {18'b0, obs_s}, 64'b0);
        end
        run_xform(1'b0, 1'b1, 1'b0, -1);
        check_tables(1'b1, "ntt8_after_reset");

        for (int r = 0; r < 8; r++) begin
            int gap;
            gap = $urandom_range(0, 4);
            for (int i = 0; i < gap; i++) begin
                step();
                check($sformatf("gap r=%0d", r), {18'b0, obs_s}, 64'b0);
            end
            run_xform(1'b0, 1'($urandom_range(0, 1)), 1'b1, -1);
            check($sformatf("rand%0d rd_cnt", r), 64'(rd_cnt), 64'd12);
            check($sformatf("rand%0d wr_cnt", r), 64'(wr_cnt), 64'd12);
        end

        run_xform(1'b1, 1'b1, 1'b1, -1);
        check("ntt256 rd_cnt", 64'(rd_cnt), 64'd1024);
        check("ntt256 wr_cnt", 64'(wr_cnt), 64'd1024);
        check("ntt256 done_cycle", 64'(done_cyc), 64'd1145);
        run_xform(1'b1, 1'b0, 1'b1, -1);
        check("intt256 rd_cnt", 64'(rd_cnt), 64'd1024);
        check("intt256 wr_cnt", 64'(wr_cnt), 64'd1024);
        check("intt256 done_cycle", 64'(done_cyc), 64'd1145);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ntt_stage_ctrl.md
# ntt_stage_ctrl

Sequencer for the shared butterfly datapath. It runs a complete N-point forward (Cooley-Tukey, sel=1) or inverse (Gentleman-Sande, sel=0) transform over one coefficient RAM. Each cycle it issues one butterfly's read addresses, twiddle index and mode bit. It drives write-back addresses aligned to the butterfly output latency and stalls at each stage boundary until the previous stage has fully written back. It sits between the top-level command interface and the coefficient RAM / twiddle ROM / butterfly trio.

## Interface
- N, 256, transform length (power of two, ≥4)
- LOGN, 8, log2(N); number of stages
- AW, 8, coefficient/twiddle address width (= LOGN)
- RD_LAT, 1, RAM/ROM read latency in cycles
- BF_LAT, 14, butterfly input-to-output latency in cycles
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request; sampled only in IDLE
- mode  in  1  1 = NTT, 0 = INTT; captured with start
- rd_en  out  1  issue strobe: read u/t/twiddle this cycle
- rd_addr_u, rd_addr_t  out  AW each  coefficient read addresses
- tw_addr  out  AW  twiddle ROM address
- bf_sel  out  1  butterfly mode, delayed RD_LAT from rd_en so it aligns with read data
- bf_vld  out  1  rd_en delayed RD_LAT
- wr_en  out  1  write-back strobe, rd_en delayed RD_LAT+BF_LAT
- wr_addr_u, wr_addr_t  out  AW each  issue addresses delayed RD_LAT+BF_LAT
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse at completion

## Operation
- States: IDLE, ISSUE, STALL, DONE.
- IDLE: start=1 latches mode, clears stage s=0, group g=0, pos p=0, and enters ISSUE. start in any other state is ignored.
- Stage geometry:
  - NTT: len = N>>(s+1).
  - INTT: len = 1<<s.
- ISSUE, one butterfly per cycle, rd_en=1:
  - rd_addr_u = g·2·len + p
  - rd_addr_t = rd_addr_u + len
  - NTT: tw_addr = (1<<s) + g
  - INTT: tw_addr = (N>>s) − 1 − g
- Index update: p increments; on p = len−1, p clears and g increments. After N/2 issues in the stage, go to STALL.
- Implement g, p, len and stage bases with counters and shifts. No dividers or multipliers.
- STALL lasts exactly RD_LAT+BF_LAT cycles with rd_en=0.
  - On exit, if s < LOGN−1: s increments, g and p clear, go to ISSUE.
  - Otherwise go to DONE.
- DONE: done=1 for one cycle, busy drops, return to IDLE.
- Delay lines: the delayed-strobe chain (bf_vld, bf_sel, wr_en, wr_addr_*) is a plain shift register, independent of FSM state. A stage's final write therefore lands in the cycle before the next stage's first read.
- Reset (asynchronous, at any time, including mid-transform):
  - FSM returns to IDLE; all counters and delay lines clear.
  - Every output is 0, including rd_en, bf_vld, wr_en, busy, done, and all addresses.
  - No write strobes from a partially completed transform may appear after release.

## Timing
- Let start be accepted at cycle 0. Stage s issues on cycles 1+s·P through N/2+s·P, with P = N/2+RD_LAT+BF_LAT.
- wr_en for an issue at cycle c is asserted at c+RD_LAT+BF_LAT. bf_vld and bf_sel for that issue are asserted at c+RD_LAT.
- done is asserted at cycle 1+LOGN·P. busy is high on cycles 1 through LOGN·P.
- Total wr_en pulses per transform: LOGN·N/2.
- mode must not affect bf_sel of an in-flight transform. The latched copy is used throughout.

## Test plan
- N=8, LOGN=3, AW=3, RD_LAT=1, BF_LAT=14, mode=1, start at cycle 0. Required issues (u,t,tw), in order:
  - Stage 0, cycles 1–4: (0,4,1) (1,5,1) (2,6,1) (3,7,1).
  - Stage 1, cycles 20–23: (0,2,2) (1,3,2) (4,6,3) (5,7,3).
  - Stage 2, cycles 39–42: (0,1,4) (2,3,5) (4,5,6) (6,7,7).
  - done at cycle 58.
- Same configuration, mode=0. Required issues:
  - Stage 0: pairs (0,1)(2,3)(4,5)(6,7) with tw 7,6,5,4.
  - Stage 1: (0,2)(1,3)(4,6)(5,7) with tw 3,3,2,2.
  - Stage 2: (0,4)..(3,7) with tw 1.
  - bf_sel=0 throughout.
- Write-back alignment, N=8: wr_en on cycles 16–19, 35–38 and 54–57 with wr_addr matching the issue 15 cycles earlier. No rd_en overlaps the STALL windows. Total 12 wr_en pulses.
- Default parameters, NTT: 1024 rd_en and 1024 wr_en pulses. done at cycle 1+8·143 = 1145. start pulses during busy are ignored and mode toggling during busy has no effect.
- Assert rst=0 at cycle 30 of an N=8 run: all outputs 0 in the same cycle. After release, 20 idle cycles show no wr_en. A new start then reproduces the first scenario exactly.
- Back-to-back: a start on the cycle after done is accepted and produces an identical second transform.
